slib_clock_div_multi: RTL and testbench

SLIB_CLOCK_DIV_MULTI -- requirements
Module: slib_clock_div_multi

---
 rtl/slib_clock_div_pkg.sv | 16 +
 rtl/slib_clock_div_chan.sv | 86 ++++++++
 rtl/slib_clock_div_multi.sv | 49 ++++
 tb/tb_slib_clock_div_multi.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slib_clock_div_pkg.sv
// Shared limits and per-channel state layout for the multi-channel clock divider.
package slib_clock_div_pkg;

  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned MIN_WIDTH    = 2;
  localparam int unsigned MAX_WIDTH    = 24;

  // Held at the widest legal size; narrower channels zero-extend into it.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] cnt;
    logic [MAX_WIDTH-1:0] act;
    logic [MAX_WIDTH-1:0] pend;
    logic                 pv;
  } chan_state_t;

endpackage

// File: rtl/slib_clock_div_chan.sv
// One divider channel: counter, active/pending divisor, tick and toggle outputs.
module slib_clock_div_chan
  import slib_clock_div_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             q_o,
  output logic             t_o,
  output logic             busy_o
);

  chan_state_t          st_q, st_d;
  logic                 q_q, q_d;
  logic                 t_q, t_d;
  logic [MAX_WIDTH-1:0] div_ext;
  logic [MAX_WIDTH-1:0] act_m1;
  logic                 halted_c;
  logic                 term_c;
  logic                 apply_c;

  assign div_ext  = MAX_WIDTH'(div_i);
  assign act_m1   = st_q.act - MAX_WIDTH'(1);
  assign halted_c = (st_q.act == '0);
  assign term_c   = !halted_c && ce_i && !sync_i && (st_q.cnt == act_m1);
  // Divisor changes only land where cnt is 0 afterwards, or the channel is idle.
  assign apply_c  = term_c || sync_i || halted_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q.cnt  <= '0;
      st_q.act  <= MAX_WIDTH'(RESET_DIV);
      st_q.pend <= '0;
      st_q.pv   <= 1'b0;
      q_q       <= 1'b0;
      t_q       <= 1'b0;
    end else begin
      st_q <= st_d;
      q_q  <= q_d;
      t_q  <= t_d;
    end
  end

  always_comb begin
    st_d = st_q;
    q_d  = 1'b0;
    t_d  = t_q;

    if (sync_i) begin
      st_d.cnt = '0;
    end else if (!halted_c && ce_i) begin
      if (term_c) begin
        st_d.cnt = '0;
        q_d      = 1'b1;
        t_d      = ~t_q;
      end else begin
        st_d.cnt = st_q.cnt + MAX_WIDTH'(1);
      end
    end

    // A load coinciding with an application event bypasses the pending slot.
    if (load_i) begin
      st_d.pend = div_ext;
      if (apply_c) begin
        st_d.act = div_ext;
        st_d.pv  = 1'b0;
      end else begin
        st_d.pv  = 1'b1;
      end
    end else if (apply_c && st_q.pv) begin
      st_d.act = st_q.pend;
      st_d.pv  = 1'b0;
    end
  end

  assign q_o    = q_q;
  assign t_o    = t_q;
  assign busy_o = st_q.pv;

endmodule

// File: rtl/slib_clock_div_multi.sv
// Bank of independent programmable clock-enable dividers sharing one clock.
module slib_clock_div_multi
  import slib_clock_div_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       CE,
  input  logic [CHANNELS-1:0]       SYNC,
  input  logic [CHANNELS-1:0]       LOAD,
  input  logic [CHANNELS*WIDTH-1:0] DIV,
  output logic [CHANNELS-1:0]       Q,
  output logic [CHANNELS-1:0]       T,
  output logic [CHANNELS-1:0]       BUSY
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $fatal(1, "slib_clock_div_multi: CHANNELS=%0d out of range 1..%0d", CHANNELS, MAX_CHANNELS);
  end

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "slib_clock_div_multi: WIDTH=%0d out of range %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end

  if (64'(RESET_DIV) >= (64'd1 << WIDTH)) begin : g_bad_reset_div
    $fatal(1, "slib_clock_div_multi: RESET_DIV=%0d does not fit in WIDTH=%0d", RESET_DIV, WIDTH);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    slib_clock_div_chan #(
      .WIDTH    (WIDTH),
      .RESET_DIV(RESET_DIV)
    ) u_chan (
      .clk_i (CLK),
      .rst_i (RST),
      .ce_i  (CE[c]),
      .sync_i(SYNC[c]),
      .load_i(LOAD[c]),
      .div_i (DIV[c*WIDTH +: WIDTH]),
      .q_o   (Q[c]),
      .t_o   (T[c]),
      .busy_o(BUSY[c])
    );
  end

endmodule

// File: tb/tb_slib_clock_div_multi.sv
// Scoreboard bench for slib_clock_div_multi with three 16-bit channels.
module tb_slib_clock_div_multi;

  localparam int unsigned CH = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned RD = 4;

  typedef struct packed {
    logic [CH-1:0] q;
    logic [CH-1:0] t;
    logic [CH-1:0] busy;
  } exp_t;

  logic            CLK;
  logic            RST;
  logic [CH-1:0]   CE;
  logic [CH-1:0]   SYNC;
  logic [CH-1:0]   LOAD;
  logic [CH*W-1:0] DIV;
  logic [CH-1:0]   Q;
  logic [CH-1:0]   T;
  logic [CH-1:0]   BUSY;

  slib_clock_div_multi #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .RESET_DIV(RD)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .CE  (CE),
    .SYNC(SYNC),
    .LOAD(LOAD),
    .DIV (DIV),
    .Q   (Q),
    .T   (T),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  exp_t exp_q[$];

  logic [W-1:0] m_cnt [CH];
  logic [W-1:0] m_act [CH];
  logic [W-1:0] m_pend[CH];
  logic         m_pv  [CH];
  logic         m_t   [CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c]  = '0;
      m_act[c]  = W'(RD);
      m_pend[c] = '0;
      m_pv[c]   = 1'b0;
      m_t[c]    = 1'b0;
    end
    exp_q.delete();
  endtask

  // Advances the reference model by one clock using the inputs now on the pins.
  task automatic model_step(output exp_t e);
    logic [W-1:0] d;
    logic         halted;
    logic         term;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      d      = DIV[c*W +: W];
      halted = (m_act[c] == 0);
      term   = !halted && CE[c] && !SYNC[c] && (32'(m_cnt[c]) + 1 == 32'(m_act[c]));
      if (SYNC[c]) m_cnt[c] = '0;
      else if (term) begin
        m_cnt[c] = '0;
        m_t[c]   = ~m_t[c];
        e.q[c]   = 1'b1;
      end else if (!halted && CE[c]) m_cnt[c] = m_cnt[c] + 1'b1;
      if (LOAD[c]) begin
        m_pend[c] = d;
        if (term || SYNC[c] || halted) begin
          m_act[c] = d;
          m_pv[c]  = 1'b0;
        end else m_pv[c] = 1'b1;
      end else if ((term || SYNC[c] || halted) && m_pv[c]) begin
        m_act[c] = m_pend[c];
        m_pv[c]  = 1'b0;
      end
      e.t[c]    = m_t[c];
      e.busy[c] = m_pv[c];
    end
  endtask

  // One clock: predict, push, clock, pop and compare. LOAD/SYNC are one-shot strobes.
  task automatic cycle();
    exp_t e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("out@%0d", cyc), 64'({Q, T, BUSY}), 64'({e.q, e.t, e.busy}));
    LOAD = '0;
    SYNC = '0;
    cyc++;
  endtask

  task automatic run(input int n, input int ch, output logic [63:0] qm,
                     output logic [63:0] bm, output int qn);
    qm = '0;
    bm = '0;
    qn = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (i < 64) begin
        qm[i] = Q[ch];
        bm[i] = BUSY[ch];
      end
      if (Q[ch]) qn++;
    end
  endtask

  task automatic set_div(input int ch, input logic [W-1:0] v);
    DIV[ch*W +: W] = v;
  endtask

  initial begin
    logic [63:0] qm, bm;
    int qn;
    int ce_n[CH];
    int q_n[CH];

    RST  = 1'b1;
    CE   = '0;
    SYNC = '0;
    LOAD = '0;
    DIV  = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", 64'({Q, T, BUSY}), 64'd0);
    RST = 1'b0;

    // Default divisor 4: ticks on the 4th, 8th and 12th enabled cycle.
    CE[0] = 1'b1;
    run(12, 0, qm, bm, qn);
    chk("div4_tick_positions", qm, 64'h888);
    chk("div4_toggle_after_3", 64'(T[0]), 64'd1);

    // Load 7 at cnt=1: old period finishes, then 7-cycle spacing.
    run(1, 0, qm, bm, qn);
    LOAD[0] = 1'b1;
    set_div(0, 16'd7);
    run(17, 0, qm, bm, qn);
    chk("div7_tick_positions", qm, 64'h10204);
    chk("div7_busy_window", bm, 64'h3);

    // Switch to 5 via load+sync, count to 3, then sync with CE high.
    LOAD[0] = 1'b1;
    SYNC[0] = 1'b1;
    set_div(0, 16'd5);
    run(1, 0, qm, bm, qn);
    chk("load_sync_no_busy", bm, 64'd0);
    run(3, 0, qm, bm, qn);
    chk("div5_no_early_tick", qm, 64'd0);
    SYNC[0] = 1'b1;
    run(6, 0, qm, bm, qn);
    chk("sync_restart_positions", qm, 64'h20);

    // Halt with divisor 0, then restart with divisor 2.
    LOAD[0] = 1'b1;
    SYNC[0] = 1'b1;
    set_div(0, 16'd0);
    run(1, 0, qm, bm, qn);
    run(100, 0, qm, bm, qn);
    chk("halted_tick_count", 64'(qn), 64'd0);
    LOAD[0] = 1'b1;
    set_div(0, 16'd2);
    run(9, 0, qm, bm, qn);
    chk("div2_tick_positions", qm, 64'h154);
    chk("div2_no_busy", bm, 64'd0);

    // Three channels with divisors 1, 3, 65535 and 50% gated enables.
    CE   = '0;
    LOAD = '1;
    SYNC = '1;
    set_div(0, 16'd1);
    set_div(1, 16'd3);
    set_div(2, 16'hFFFF);
    cycle();
    for (int c = 0; c < CH; c++) begin
      ce_n[c] = 0;
      q_n[c]  = 0;
    end
    for (int i = 0; i < 400; i++) begin
      CE[0] = i[0];
      CE[1] = ~i[0];
      CE[2] = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) if (CE[c]) ce_n[c]++;
      cycle();
      for (int c = 0; c < CH; c++) if (Q[c]) q_n[c]++;
    end
    chk("ch0_div1_ticks", 64'(q_n[0]), 64'(ce_n[0]));
    chk("ch1_div3_ticks", 64'(q_n[1]), 64'(ce_n[1] / 3));
    chk("ch2_div65535_ticks", 64'(q_n[2]), 64'd0);

    // Reset mid-period with a pending divisor on channel 1.
    CE      = '0;
    LOAD[1] = 1'b1;
    set_div(1, 16'd9);
    cycle();
    chk("pending_busy_before_reset", 64'(BUSY[1]), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({Q, T, BUSY}), 64'd0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("held_reset_outputs", 64'({Q, T, BUSY}), 64'd0);
    RST   = 1'b0;
    CE[1] = 1'b1;
    run(4, 1, qm, bm, qn);
    chk("post_reset_div4_positions", qm, 64'h8);
    chk("post_reset_no_busy", bm, 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
